// File: rtl/ssd_debug_display.sv
// Debug-word viewer: captures one 32-bit word from the datapath debug bus and scans half of it
// onto a 4-digit common-anode hex display; also debounces the step button into a 1-cycle pulse.
module ssd_debug_display #(
    parameter int REFRESH_BITS    = 18,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_WORDS       = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*NUM_WORDS-1:0]   dbg_bus,
    input  logic [3:0]                sel,
    input  logic                      upper,
    input  logic                      btn_step,
    output logic [3:0]                anode,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      step_pulse
);

    localparam int              DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]      SEG_DASH = 7'b0111111;
    localparam logic [6:0]      SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } db_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Two-flop synchronizers for the switch and button inputs
    logic [3:0] sel_meta, sel_s;
    logic       upper_meta, upper_s;
    logic       btn_meta, btn_s;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sel_meta   <= '0;
            sel_s      <= '0;
            upper_meta <= 1'b0;
            upper_s    <= 1'b0;
            btn_meta   <= 1'b0;
            btn_s      <= 1'b0;
        end else begin
            sel_meta   <= sel;
            sel_s      <= sel_meta;
            upper_meta <= upper;
            upper_s    <= upper_meta;
            btn_meta   <= btn_step;
            btn_s      <= btn_meta;
        end
    end

    logic [31:0] words [NUM_WORDS];

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
        assign words[i] = dbg_bus[32*i +: 32];
    end

    logic        sel_valid;
    logic [31:0] sel_word;
    logic [15:0] sel_half;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_word  = '0;
        sel_valid = (int'(sel_s) < NUM_WORDS);
        if (sel_valid) begin
            sel_word = words[sel_s];
        end
        sel_half = upper_s ? sel_word[31:16] : sel_word[15:0];
    end

    // Scan counter, tear-free frame register and registered display drivers
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [1:0]              digit;
    logic [15:0]             frame;
    logic                    frame_dash;
    logic                    frame_upper;
    logic [3:0]              nibble;

    assign digit  = scan_cnt[REFRESH_BITS-1 -: 2];
    assign nibble = frame[4*digit +: 4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt    <= '0;
            frame       <= '0;
            frame_dash  <= 1'b0;
            frame_upper <= 1'b0;
            anode       <= 4'b1111;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            // Only reload as the counter wraps, so a frame never mixes two words
            if (scan_cnt == '1) begin
                frame       <= sel_half;
                frame_dash  <= !sel_valid;
                frame_upper <= upper_s;
            end
            anode <= ~(4'b0001 << digit);
            seg   <= frame_dash ? SEG_DASH : hex_to_seg(nibble);
            dp    <= !(frame_upper && (digit == 2'd3));
        end
    end

    // Step-button debounce FSM
    db_state_t       state, state_next;
    logic [DB_W-1:0] db_cnt, db_cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next  = PRESS;
                    db_cnt_next = '0;
                end
            end
            PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = HELD;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next  = RELEASE;
                    db_cnt_next = '0;
                end
            end
            RELEASE: begin
                if (btn_s) begin
                    state_next = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        step_pulse = (state == PRESS) && btn_s && (db_cnt == DB_LAST);
    end

endmodule

// File: tb/tb_ssd_debug_display.sv
// Scoreboard bench for ssd_debug_display: stimulus queues expected digit presentations and
// step-pulse cycles; monitors pop and compare as the DUT presents them.
module tb_ssd_debug_display;

    localparam int NW = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic [32*NW-1:0]  dbg_bus;
    logic [3:0]        sel;
    logic              upper;
    logic              btn_step;
    logic [3:0]        anode;
    logic [6:0]        seg;
    logic              dp;
    logic              step_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];

    ssd_debug_display #(
        .REFRESH_BITS   (4),
        .DEBOUNCE_CYCLES(4),
        .NUM_WORDS      (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dbg_bus   (dbg_bus),
        .sel       (sel),
        .upper     (upper),
        .btn_step  (btn_step),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // Queue one frame of four digit presentations, rightmost digit first
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic up);
        exp_q.push_back('{an: 4'b1110, sg: s0, dp: 1'b1});
        exp_q.push_back('{an: 4'b1101, sg: s1, dp: 1'b1});
        exp_q.push_back('{an: 4'b1011, sg: s2, dp: 1'b1});
        exp_q.push_back('{an: 4'b0111, sg: s3, dp: !up});
    endtask

    // Wait until the display moves onto the given anode pattern, then step past the edge
    task automatic wait_anode(input logic [3:0] target);
        int n = 0;
        while (anode === target && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (anode !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) timeout_fail("wait_anode");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("wait_drain");
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Display monitor: each new anode pattern is one digit presentation
    logic [3:0] prev_anode = 4'b1111;
    int         hold_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b1) begin
            prev_anode = 4'b1111;
            hold_cnt   = 0;
        end else begin
            hold_cnt++;
            if (anode !== prev_anode) begin
                if (prev_anode !== 4'b1111 && anode !== 4'b1111) begin
                    check("digit_hold_cycles", hold_cnt, 4);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("anode", {28'd0, anode}, {28'd0, e.an});
                    check("seg", {25'd0, seg}, {25'd0, e.sg});
                    check("dp", {31'd0, dp}, {31'd0, e.dp});
                end
                prev_anode = anode;
                hold_cnt   = 0;
            end
        end
    end

    // Step-pulse monitor: every high sample must match a queued cycle number
    always @(negedge clk) begin
        if (reset === 1'b1 && step_pulse === 1'b1) begin
            if (pulse_q.size() > 0) begin
                check("step_pulse_cycle", cyc, pulse_q.pop_front());
            end else begin
                check("step_pulse_unexpected", {31'd0, step_pulse}, 32'd0);
            end
        end
    end

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110, SDASH = 7'b0111111;

    initial begin
        reset    = 1'b0;
        sel      = 4'd0;
        upper    = 1'b0;
        btn_step = 1'b0;
        for (int i = 0; i < NW; i++) dbg_bus[32*i +: 32] = 32'h0101_0101 * i;
        dbg_bus[32*10 +: 32] = 32'h1234_ABCD;
        dbg_bus[32*12 +: 32] = 32'hDEAD_BEEF;

        // Reset asserted mid-frame while the button is mid-debounce
        cycles(3);
        reset = 1'b1;
        cycles(10);
        btn_step = 1'b1;
        cycles(3);
        reset = 1'b0;
        #1;
        check("reset_anode", {28'd0, anode}, 32'h0000_000F);
        check("reset_seg", {25'd0, seg}, 32'h0000_007F);
        check("reset_dp", {31'd0, dp}, 32'd1);
        check("reset_step_pulse", {31'd0, step_pulse}, 32'd0);
        btn_step = 1'b0;
        sel      = 4'd10;
        upper    = 1'b0;

        // First frame shows the cleared frame register, second the low half of word 10
        push_frame(S0, S0, S0, S0, 1'b0);
        push_frame(SD, SC, SB, SA, 1'b0);
        cycles(2);
        reset = 1'b1;
        wait_drain();

        // Upper half of word 10, dp marks digit 3
        upper = 1'b1;
        wait_anode(4'b0111);
        push_frame(S4, S3, S2, S1, 1'b1);
        wait_drain();

        // Mid-frame switch from word 10 to word 12 takes effect only at the wrap
        sel   = 4'd10;
        upper = 1'b0;
        wait_anode(4'b0111);
        exp_q.push_back('{an: 4'b1110, sg: SD, dp: 1'b1});
        exp_q.push_back('{an: 4'b1101, sg: SC, dp: 1'b1});
        wait_anode(4'b1101);
        sel = 4'd12;
        exp_q.push_back('{an: 4'b1011, sg: SB, dp: 1'b1});
        exp_q.push_back('{an: 4'b0111, sg: SA, dp: 1'b1});
        push_frame(SF, SE, SE, SB, 1'b0);
        wait_drain();

        upper = 1'b1;
        wait_anode(4'b0111);
        push_frame(SD, SA, SE, SD, 1'b1);
        wait_drain();

        // Out-of-range selects show dashes
        sel   = 4'd13;
        upper = 1'b1;
        wait_anode(4'b0111);
        push_frame(SDASH, SDASH, SDASH, SDASH, 1'b1);
        wait_drain();

        sel   = 4'd14;
        upper = 1'b0;
        wait_anode(4'b0111);
        push_frame(SDASH, SDASH, SDASH, SDASH, 1'b0);
        wait_drain();

        // Button: short glitch gives nothing
        btn_step = 1'b1;
        cycles(2);
        btn_step = 1'b0;
        cycles(10);

        // Clean press: 2 synchronizer + 4 debounce cycles after the rise; bouncy release
        btn_step = 1'b1;
        pulse_q.push_back(cyc + 6);
        cycles(20);
        btn_step = 1'b0;
        cycles(1);
        btn_step = 1'b1;
        cycles(1);
        btn_step = 1'b0;
        cycles(1);
        btn_step = 1'b1;
        cycles(1);
        btn_step = 1'b0;
        cycles(12);

        // A second clean press proves the FSM returned to IDLE after the release
        btn_step = 1'b1;
        pulse_q.push_back(cyc + 6);
        cycles(10);
        btn_step = 1'b0;
        cycles(10);

        check("display_queue_empty", exp_q.size(), 0);
        check("pulse_queue_empty", pulse_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
